mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
Parametrised N:1 registered multiplexer, the successor to the 4:1 combinational mux.
- Manual mode: channel chosen by select input.
- Scan mode: an internal sequencer steps through the enabled channels, dwelling a fixed number of cycles on each.
- Output is registered, with valid and wrap strobes; sits between channel sources and a single downstream consumer.

Parameters:
- WIDTH, 1, data bits per channel
- N, 4, number of channels (>=2)
- SEL_W, 2, select width = $clog2(N)
- DWELL, 4, cycles spent on each channel in scan mode (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- i  input  N*WIDTH  channel data; channel k = i[k*WIDTH +: WIDTH]
- s  input  SEL_W  manual channel select
- mode  input  1  0 = manual, 1 = scan
- en_mask  input  N  per-channel enable; bit k enables channel k
- o  output  WIDTH  registered selected data
- sel_o  output  SEL_W  channel index that produced o
- o_valid  output  1  o is from an enabled, in-range channel
- wrap  output  1  one-cycle pulse when scan returns to the lowest enabled channel

Behaviour:
- Reset (async, rst=1): o=0, sel_o=0, o_valid=0, wrap=0, dwell counter=0, state=MANUAL. Outputs stay at these values while rst is high. Operation resumes on the first clk edge after deassertion.
- States: MANUAL, SCAN, HOLD. Transitions are evaluated at each rising edge:
  - mode=0 -> MANUAL
  - mode=1 and en_mask!=0 -> SCAN
  - mode=1 and en_mask==0 -> HOLD
- MANUAL: one-cycle latency. At edge: sel_o<=s.
  - If s<N and en_mask[s]: o<=channel s, o_valid<=1.
  - Otherwise: o<=0, o_valid<=0.
  - Dwell counter held at 0; wrap=0.
- Entry to SCAN from MANUAL or HOLD: sel_o<=lowest enabled index, dwell<=0, wrap<=0.
- SCAN, every cycle: o<=channel sel_o (live sample), o_valid<=1.
  - dwell increments 0..DWELL-1.
  - When dwell==DWELL-1: dwell<=0 and sel_o<=next enabled index above sel_o. If none exists, wrap to the lowest enabled index and pulse wrap=1 for exactly one cycle, coincident with the new sel_o.
- Mask change in SCAN: if en_mask[sel_o] drops to 0, advance to the next enabled channel on the following edge regardless of dwell, and reset dwell to 0. Wrap rules apply to this advance.
- Single enabled channel: sel_o stays constant; wrap pulses once every DWELL cycles.
- DWELL=1: advance every cycle.
- HOLD: o<=0, o_valid<=0, wrap<=0; sel_o holds its last value.
- mode 1->0 mid-dwell: next edge behaves as MANUAL; dwell cleared; no wrap.
- Non-power-of-2 N: indices >=N are never produced by the sequencer. In manual mode they give o_valid=0.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package mux_scan_pkg:
  - state encoding (MANUAL=2'd0, SCAN=2'd1, HOLD=2'd2)
  - mode constants MODE_MANUAL / MODE_SCAN
  - function computing $clog2 for SEL_W checks
- Sub-module mux_scan_next (combinational). Given en_mask and the current index, it returns the next enabled index above current, a wrapped flag, and the lowest enabled index. It is a rotate-and-priority-encode over N bits.

Test Plan:
- Manual sweep. N=4, WIDTH=1, i=4'b1010, en_mask=4'b1111, mode=0, s=0,1,3,2 each for 10 cycles. Expected (o, o_valid) one cycle after each change: o=0,1,1,0 with o_valid=1 throughout.
- Manual masked. en_mask=4'b1101, s=1. Expected one cycle later: o=0, o_valid=0, sel_o=1.
- Scan full mask. mode=1, DWELL=4, en_mask=4'b1111. Expected sel_o sequence 0,1,2,3,0 changing every 4 cycles; wrap high for the single cycle sel_o returns to 0; o tracks i=4'b1010.
- Scan sparse mask plus mid-dwell drop. en_mask=4'b1010, so sel_o alternates 1,3. Clear bit 3 at dwell=1 while sel_o=3. Expected: the next edge gives sel_o=1, wrap=1, dwell restarts. Thereafter sel_o stays at 1 and wrap pulses every 4 cycles.
- Empty mask and mode exit. mode=1, en_mask=0. Expected: HOLD with o=0, o_valid=0, sel_o frozen. Then set en_mask=4'b0100: SCAN entry with sel_o=2. Then mode=0 with s=0: MANUAL on the next edge, o=i[0]=0.
- Async reset mid-scan. Assert rst between clock edges during SCAN. Expected immediately: o=0, sel_o=0, o_valid=0, wrap=0. After release with mode=1 and en_mask=4'b1111, scan restarts at channel 0 with dwell=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the scanning N:1 multiplexer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Number of bits needed to index n channels, never less than 1.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Finds the next enabled channel above the current one, wrapping to the
// lowest enabled channel when none remains above.
module mux_scan_next
    import mux_scan_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     en_mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] next_idx,
    output logic             wrapped,
    output logic [SEL_W-1:0] lowest
);

    logic [SEL_W-1:0] above;
    logic             above_found;

    // Descending priority scan: the last hit is the smallest qualifying index.
    always_comb begin
        lowest      = '0;
        above       = '0;
        above_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                lowest = SEL_W'(k);
                if (SEL_W'(k) > cur) begin
                    above       = SEL_W'(k);
                    above_found = 1'b1;
                end
            end
        end
        next_idx = above_found ? above : lowest;
        wrapped  = ~above_found;
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with manual select and an automatic scan
// sequencer that dwells a fixed number of cycles on each enabled channel.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   i,
    input  logic [SEL_W-1:0]     s,
    input  logic                 mode,
    input  logic [N-1:0]         en_mask,
    output logic [WIDTH-1:0]     o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 o_valid,
    output logic                 wrap
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    if (SEL_W < sel_width(N)) begin : g_sel_w_check
        $error("mux_scan_n: SEL_W too narrow for N channels");
    end

    state_t            state_q, state_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [SEL_W-1:0]  sel_d;
    logic [WIDTH-1:0]  o_d;
    logic              valid_d;
    logic              wrap_d;
    logic              s_enabled;
    logic              cur_enabled;
    logic [SEL_W-1:0]  scan_next;
    logic [SEL_W-1:0]  scan_lowest;
    logic              scan_wrap;

    mux_scan_next #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_next (
        .en_mask  (en_mask),
        .cur      (sel_o),
        .next_idx (scan_next),
        .wrapped  (scan_wrap),
        .lowest   (scan_lowest)
    );

    // Next state and next output values; out-of-range indices read as disabled.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_o;
        dwell_d     = '0;
        wrap_d      = 1'b0;
        valid_d     = 1'b0;
        o_d         = '0;
        s_enabled   = 1'b0;
        cur_enabled = 1'b0;

        for (int k = 0; k < N; k++) begin
            if (s == SEL_W'(k)) begin
                s_enabled = en_mask[k];
            end
            if (sel_o == SEL_W'(k)) begin
                cur_enabled = en_mask[k];
            end
        end

        if (mode == MODE_MANUAL) begin
            state_d = MANUAL;
        end else if (en_mask == '0) begin
            state_d = HOLD;
        end else begin
            state_d = SCAN;
        end

        case (state_d)
            MANUAL: begin
                sel_d   = s;
                valid_d = s_enabled;
            end
            SCAN: begin
                valid_d = 1'b1;
                if (state_q != SCAN) begin
                    sel_d = scan_lowest;
                end else if (!cur_enabled || dwell_q == DWELL_LAST) begin
                    sel_d  = scan_next;
                    wrap_d = scan_wrap;
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            default: begin
            end
        endcase

        for (int k = 0; k < N; k++) begin
            if (valid_d && sel_d == SEL_W'(k)) begin
                o_d = i[k*WIDTH +: WIDTH];
            end
        end
    end

    // State and all outputs are registered; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MANUAL;
            dwell_q <= '0;
            sel_o   <= '0;
            o       <= '0;
            o_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            sel_o   <= sel_d;
            o       <= o_d;
            o_valid <= valid_d;
            wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n with a behavioural model of the scan rules.
module tb_mux_scan_n;

    localparam int WIDTH = 4;
    localparam int N     = 5;
    localparam int SEL_W = 3;
    localparam int DWELL = 3;
    localparam int IW    = N * WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IW-1:0]     i = '0;
    logic [SEL_W-1:0]  s = '0;
    logic              mode = 1'b0;
    logic [N-1:0]      en_mask = '1;
    logic [WIDTH-1:0]  o;
    logic [SEL_W-1:0]  sel_o;
    logic              o_valid;
    logic              wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [WIDTH-1:0] o;
        logic [SEL_W-1:0] sel;
        logic             valid;
        logic             wrap;
    } exp_t;

    exp_t exp_q[$];

    bit m_scan  = 1'b0;
    int m_sel   = 0;
    int m_dwell = 0;

    mux_scan_n #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .s       (s),
        .mode    (mode),
        .en_mask (en_mask),
        .o       (o),
        .sel_o   (sel_o),
        .o_valid (o_valid),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] chan(input logic [IW-1:0] bus, input int k);
        logic [IW-1:0] sh;
        sh = bus >> (k * WIDTH);
        return sh[WIDTH-1:0];
    endfunction

    // Smallest enabled channel strictly above 'from', or -1 if none.
    function automatic int first_enabled_above(input logic [N-1:0] m, input int from);
        for (int k = from + 1; k < N; k++) begin
            if (m[k]) return k;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] sel,
                                 input logic [N-1:0] mask, input int cycles);
        mode    = m;
        s       = sel;
        en_mask = mask;
        repeat (cycles) begin
            i = IW'($urandom);
            @(negedge clk);
        end
    endtask

    // Model state is cleared the moment reset rises, like the DUT.
    always @(posedge rst) begin
        m_scan  = 1'b0;
        m_sel   = 0;
        m_dwell = 0;
    end

    // Reference model: predicts the registered outputs for each rising edge.
    always @(posedge clk) begin
        exp_t e;
        int   sv;
        int   nxt;
        e = '0;
        if (rst) begin
            m_scan  = 1'b0;
            m_sel   = 0;
            m_dwell = 0;
        end else if (mode == 1'b0) begin
            m_scan  = 1'b0;
            m_dwell = 0;
            sv      = int'(s);
            m_sel   = sv;
            e.sel   = s;
            if (sv < N && en_mask[sv]) begin
                e.valid = 1'b1;
                e.o     = chan(i, sv);
            end
        end else if (en_mask == '0) begin
            m_scan  = 1'b0;
            m_dwell = 0;
            e.sel   = SEL_W'(m_sel);
        end else begin
            if (!m_scan) begin
                m_sel   = first_enabled_above(en_mask, -1);
                m_dwell = 0;
            end else if (!en_mask[m_sel] || m_dwell == DWELL - 1) begin
                nxt = first_enabled_above(en_mask, m_sel);
                if (nxt < 0) begin
                    nxt    = first_enabled_above(en_mask, -1);
                    e.wrap = 1'b1;
                end
                m_sel   = nxt;
                m_dwell = 0;
            end else begin
                m_dwell = m_dwell + 1;
            end
            m_scan  = 1'b1;
            e.sel   = SEL_W'(m_sel);
            e.valid = 1'b1;
            e.o     = chan(i, m_sel);
        end
        exp_q.push_back(e);
    end

    // Monitor: compares every registered output word against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        a = {o, sel_o, o_valid, wrap};
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underflow", 32'(a), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            checkOutput("outputs{o,sel,valid,wrap}", 32'(a), 32'(e));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Manual sweep over every select value, in and out of range.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, SEL_W'(k), '1, 2);
            applyStimulus(1'b0, SEL_W'(k), N'($urandom), 2);
        end

        // Full-mask scan, then sparse scan with a channel dropped mid-dwell.
        applyStimulus(1'b1, '0, '1, 20);
        applyStimulus(1'b1, '0, 5'b01010, 10);
        applyStimulus(1'b1, '0, 5'b00010, 10);

        // Empty mask holds, re-entry to scan, then back to manual.
        applyStimulus(1'b1, '0, '0, 5);
        applyStimulus(1'b1, '0, 5'b00100, 5);
        applyStimulus(1'b0, '0, 5'b00100, 3);

        // Randomised mode, select and mask changes.
        repeat (150) begin
            applyStimulus(($urandom_range(0, 3) != 0), SEL_W'($urandom),
                          ($urandom_range(0, 5) == 0) ? '0 : N'($urandom),
                          $urandom_range(1, 8));
        end

        // Asynchronous reset between edges while scanning.
        applyStimulus(1'b1, '0, '1, 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_o", 32'(o), 32'd0);
        checkOutput("async_reset_sel_o", 32'(sel_o), 32'd0);
        checkOutput("async_reset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("async_reset_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, '0, '1, 15);

        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
